// File: rtl/map_table.sv
// Two-wide register-rename map table.
// Holds the speculative map, per-arch-reg ready bits and the retirement map used
// for single-cycle recovery on a branch mispredict. Lookups are combinational on
// current state; all state changes take effect at the next rising clock edge.
module map_table #(
  parameter int unsigned NUM_ARCH = 32,
  parameter int unsigned TAG_W    = 7
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  id_dispatch_num,
  input  logic [$clog2(NUM_ARCH)-1:0] id_dest_a,
  input  logic [$clog2(NUM_ARCH)-1:0] id_dest_b,
  input  logic [$clog2(NUM_ARCH)-1:0] id_src1_a,
  input  logic [$clog2(NUM_ARCH)-1:0] id_src2_a,
  input  logic [$clog2(NUM_ARCH)-1:0] id_src1_b,
  input  logic [$clog2(NUM_ARCH)-1:0] id_src2_b,
  input  logic [TAG_W-1:0]            fl_mt_a,
  input  logic [TAG_W-1:0]            fl_mt_b,
  input  logic                        cdb_valid_a,
  input  logic                        cdb_valid_b,
  input  logic [TAG_W-1:0]            cdb_tag_a,
  input  logic [TAG_W-1:0]            cdb_tag_b,
  input  logic [1:0]                  rob_retire_num,
  input  logic [$clog2(NUM_ARCH)-1:0] rob_retire_dest_a,
  input  logic [$clog2(NUM_ARCH)-1:0] rob_retire_dest_b,
  input  logic [TAG_W-1:0]            rob_retire_tag_a,
  input  logic [TAG_W-1:0]            rob_retire_tag_b,
  input  logic                        branch_mispredict,
  output logic [TAG_W-1:0]            mt_src1_a,
  output logic [TAG_W-1:0]            mt_src2_a,
  output logic [TAG_W-1:0]            mt_src1_b,
  output logic [TAG_W-1:0]            mt_src2_b,
  output logic                        mt_rdy1_a,
  output logic                        mt_rdy2_a,
  output logic                        mt_rdy1_b,
  output logic                        mt_rdy2_b,
  output logic [TAG_W-1:0]            mt_told_a,
  output logic [TAG_W-1:0]            mt_told_b
);

  localparam int unsigned AW = $clog2(NUM_ARCH);

  logic [TAG_W-1:0] spec_map_q [NUM_ARCH];
  logic [TAG_W-1:0] spec_map_d [NUM_ARCH];
  logic [TAG_W-1:0] arch_map_q [NUM_ARCH];
  logic [TAG_W-1:0] arch_map_d [NUM_ARCH];
  logic             ready_q    [NUM_ARCH];
  logic             ready_d    [NUM_ARCH];

  logic disp_a, disp_b, ret_a, ret_b, pair;

  // Dispatch count 3 is treated as no dispatch.
  assign disp_a = (id_dispatch_num == 2'd1) || (id_dispatch_num == 2'd2);
  assign disp_b = (id_dispatch_num == 2'd2);
  assign pair   = disp_b;
  assign ret_a  = (rob_retire_num != 2'd0);
  assign ret_b  = (rob_retire_num == 2'd2);

  // A tag on either CDB slot this cycle is ready now.
  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag, input logic va,
                                   input logic [TAG_W-1:0] ta, input logic vb,
                                   input logic [TAG_W-1:0] tb);
    return (va && (ta == tag)) || (vb && (tb == tag));
  endfunction

  // Source lookup with CDB bypass, intra-bundle forwarding for slot b, and told.
  always_comb begin
    mt_src1_a = spec_map_q[id_src1_a];
    mt_src2_a = spec_map_q[id_src2_a];
    mt_src1_b = spec_map_q[id_src1_b];
    mt_src2_b = spec_map_q[id_src2_b];
    mt_rdy1_a = ready_q[id_src1_a] ||
                cdb_hit(mt_src1_a, cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b);
    mt_rdy2_a = ready_q[id_src2_a] ||
                cdb_hit(mt_src2_a, cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b);
    mt_rdy1_b = ready_q[id_src1_b] ||
                cdb_hit(mt_src1_b, cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b);
    mt_rdy2_b = ready_q[id_src2_b] ||
                cdb_hit(mt_src2_b, cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b);
    // Slot b reads the value produced by slot a in the same bundle.
    if (pair && (id_src1_b == id_dest_a)) begin
      mt_src1_b = fl_mt_a;
      mt_rdy1_b = 1'b0;
    end
    if (pair && (id_src2_b == id_dest_a)) begin
      mt_src2_b = fl_mt_a;
      mt_rdy2_b = 1'b0;
    end
    mt_told_a = spec_map_q[id_dest_a];
    mt_told_b = (pair && (id_dest_b == id_dest_a)) ? fl_mt_a : spec_map_q[id_dest_b];
  end

  // Next-state: retire into arch map; recover or apply CDB then dispatch to spec map.
  always_comb begin
    for (int i = 0; i < NUM_ARCH; i++) begin
      arch_map_d[i] = arch_map_q[i];
      spec_map_d[i] = spec_map_q[i];
      ready_d[i]    = ready_q[i];
    end
    if (ret_a) arch_map_d[rob_retire_dest_a] = rob_retire_tag_a;
    if (ret_b) arch_map_d[rob_retire_dest_b] = rob_retire_tag_b;

    if (branch_mispredict) begin
      // Recovery includes retires committing in this same cycle.
      for (int i = 0; i < NUM_ARCH; i++) begin
        spec_map_d[i] = arch_map_d[i];
        ready_d[i]    = 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        if (cdb_hit(spec_map_q[i], cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b)) begin
          ready_d[i] = 1'b1;
        end
      end
      // Dispatch clears are applied after CDB sets so they take priority.
      if (disp_a) begin
        spec_map_d[id_dest_a] = fl_mt_a;
        ready_d[id_dest_a]    = 1'b0;
      end
      if (disp_b) begin
        spec_map_d[id_dest_b] = fl_mt_b;
        ready_d[id_dest_b]    = 1'b0;
      end
    end
  end

  // State registers; synchronous reset to the identity mapping, all ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        spec_map_q[i] <= TAG_W'(i);
        arch_map_q[i] <= TAG_W'(i);
        ready_q[i]    <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        spec_map_q[i] <= spec_map_d[i];
        arch_map_q[i] <= arch_map_d[i];
        ready_q[i]    <= ready_d[i];
      end
    end
  end

  logic unused_aw;
  assign unused_aw = (AW == 0);

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: hand-computed expectations for rename, bypass,
// forwarding, retire/recovery, reset priority and the ignored dispatch count.
module tb_map_table;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] id_dispatch_num;
  logic [4:0] id_dest_a, id_dest_b, id_src1_a, id_src2_a, id_src1_b, id_src2_b;
  logic [6:0] fl_mt_a, fl_mt_b;
  logic       cdb_valid_a, cdb_valid_b;
  logic [6:0] cdb_tag_a, cdb_tag_b;
  logic [1:0] rob_retire_num;
  logic [4:0] rob_retire_dest_a, rob_retire_dest_b;
  logic [6:0] rob_retire_tag_a, rob_retire_tag_b;
  logic       branch_mispredict;
  logic [6:0] mt_src1_a, mt_src2_a, mt_src1_b, mt_src2_b, mt_told_a, mt_told_b;
  logic       mt_rdy1_a, mt_rdy2_a, mt_rdy1_b, mt_rdy2_b;

  int passed = 0;
  int total  = 0;

  map_table #(.NUM_ARCH(32), .TAG_W(7)) dut (
    .clock(clock), .reset(reset), .id_dispatch_num(id_dispatch_num),
    .id_dest_a(id_dest_a), .id_dest_b(id_dest_b),
    .id_src1_a(id_src1_a), .id_src2_a(id_src2_a),
    .id_src1_b(id_src1_b), .id_src2_b(id_src2_b),
    .fl_mt_a(fl_mt_a), .fl_mt_b(fl_mt_b),
    .cdb_valid_a(cdb_valid_a), .cdb_valid_b(cdb_valid_b),
    .cdb_tag_a(cdb_tag_a), .cdb_tag_b(cdb_tag_b),
    .rob_retire_num(rob_retire_num),
    .rob_retire_dest_a(rob_retire_dest_a), .rob_retire_dest_b(rob_retire_dest_b),
    .rob_retire_tag_a(rob_retire_tag_a), .rob_retire_tag_b(rob_retire_tag_b),
    .branch_mispredict(branch_mispredict),
    .mt_src1_a(mt_src1_a), .mt_src2_a(mt_src2_a),
    .mt_src1_b(mt_src1_b), .mt_src2_b(mt_src2_b),
    .mt_rdy1_a(mt_rdy1_a), .mt_rdy2_a(mt_rdy2_a),
    .mt_rdy1_b(mt_rdy1_b), .mt_rdy2_b(mt_rdy2_b),
    .mt_told_a(mt_told_a), .mt_told_b(mt_told_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic idle();
    reset = 1'b0; id_dispatch_num = 2'd0;
    id_dest_a = 5'd0; id_dest_b = 5'd0;
    id_src1_a = 5'd0; id_src2_a = 5'd0; id_src1_b = 5'd0; id_src2_b = 5'd0;
    fl_mt_a = 7'd0; fl_mt_b = 7'd0;
    cdb_valid_a = 1'b0; cdb_valid_b = 1'b0; cdb_tag_a = 7'd0; cdb_tag_b = 7'd0;
    rob_retire_num = 2'd0; rob_retire_dest_a = 5'd0; rob_retire_dest_b = 5'd0;
    rob_retire_tag_a = 7'd0; rob_retire_tag_b = 7'd0;
    branch_mispredict = 1'b0;
  endtask

  // Commit current inputs at the next rising edge, then settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    // Reset state: identity mapping, all ready.
    id_src1_a = 5'd9; id_src2_b = 5'd31; id_dest_a = 5'd4;
    #1;
    check("rst_src1_a", mt_src1_a, 9);
    check("rst_rdy1_a", mt_rdy1_a, 1);
    check("rst_src2_b", mt_src2_b, 31);
    check("rst_told_a", mt_told_a, 4);
    reset = 1'b0;

    // Rename r3 -> 32.
    idle(); id_dispatch_num = 2'd1; id_dest_a = 5'd3; fl_mt_a = 7'd32;
    #1;
    check("told_a_r3", mt_told_a, 3);
    tick();
    idle(); id_src1_a = 5'd3; id_src2_a = 5'd4;
    #1;
    check("src1_a_r3", mt_src1_a, 32);
    check("rdy1_a_r3", mt_rdy1_a, 0);
    check("src2_a_r4", mt_src2_a, 4);
    check("rdy2_a_r4", mt_rdy2_a, 1);
    tick();

    // CDB bypass on tag 32, then the ready bit persists.
    idle(); id_src1_a = 5'd3; cdb_valid_a = 1'b1; cdb_tag_a = 7'd32;
    #1;
    check("bypass_rdy1_a", mt_rdy1_a, 1);
    check("bypass_src1_a", mt_src1_a, 32);
    tick();
    idle(); id_src1_a = 5'd3;
    #1;
    check("cdb_kept_rdy", mt_rdy1_a, 1);

    // Two-wide rename to the same dest r5 with intra-bundle forwarding.
    idle(); id_dispatch_num = 2'd2; id_dest_a = 5'd5; id_dest_b = 5'd5;
    fl_mt_a = 7'd40; fl_mt_b = 7'd41;
    id_src1_b = 5'd5; id_src2_b = 5'd3; id_src1_a = 5'd5;
    #1;
    check("fwd_src1_b", mt_src1_b, 40);
    check("fwd_rdy1_b", mt_rdy1_b, 0);
    check("pair_told_a", mt_told_a, 5);
    check("pair_told_b", mt_told_b, 40);
    check("nofwd_src2_b", mt_src2_b, 32);
    check("nofwd_rdy2_b", mt_rdy2_b, 1);
    check("a_nofwd_src1", mt_src1_a, 5);
    check("a_nofwd_rdy1", mt_rdy1_a, 1);
    tick();
    idle(); id_src1_a = 5'd5; id_dest_b = 5'd3; cdb_valid_b = 1'b1; cdb_tag_b = 7'd40;
    #1;
    check("b_wins_src1_a", mt_src1_a, 41);
    check("stale_cdb_rdy", mt_rdy1_a, 0);
    check("told_b_lookup", mt_told_b, 32);
    tick();
    // CDB slot b completes tag 41; bypass on slot b, then state update.
    idle(); id_src1_b = 5'd5; cdb_valid_b = 1'b1; cdb_tag_b = 7'd41;
    #1;
    check("cdbb_rdy1_b", mt_rdy1_b, 1);
    tick();
    idle(); id_src1_a = 5'd5;
    #1;
    check("cdbb_kept_rdy", mt_rdy1_a, 1);

    // Dispatch clear beats a CDB set on the same arch reg (r5 maps to 41 now).
    idle(); id_dispatch_num = 2'd1; id_dest_a = 5'd5; fl_mt_a = 7'd45;
    cdb_valid_a = 1'b1; cdb_tag_a = 7'd41;
    tick();
    idle(); id_src1_a = 5'd5;
    #1;
    check("disp_beats_cdb_src", mt_src1_a, 45);
    check("disp_beats_cdb_rdy", mt_rdy1_a, 0);

    // Rename r7 -> 50, r8 -> 51; retire (r7, 50) with mispredict.
    idle(); id_dispatch_num = 2'd2; id_dest_a = 5'd7; id_dest_b = 5'd8;
    fl_mt_a = 7'd50; fl_mt_b = 7'd51;
    tick();
    idle(); rob_retire_num = 2'd1; rob_retire_dest_a = 5'd7; rob_retire_tag_a = 7'd50;
    branch_mispredict = 1'b1; id_dispatch_num = 2'd1; id_dest_a = 5'd9; fl_mt_a = 7'd60;
    tick();
    idle(); id_src1_a = 5'd7; id_src2_a = 5'd8; id_src1_b = 5'd5; id_src2_b = 5'd9;
    #1;
    check("rec_src1_a_r7", mt_src1_a, 50);
    check("rec_rdy1_a_r7", mt_rdy1_a, 1);
    check("rec_src2_a_r8", mt_src2_a, 8);
    check("rec_rdy2_a_r8", mt_rdy2_a, 1);
    check("rec_src1_b_r5", mt_src1_b, 5);
    check("rec_src2_b_r9", mt_src2_b, 9);
    check("rec_rdy2_b_r9", mt_rdy2_b, 1);

    // Dispatch count 3 changes nothing.
    idle(); id_dispatch_num = 2'd3; id_dest_a = 5'd10; id_dest_b = 5'd11;
    fl_mt_a = 7'd60; fl_mt_b = 7'd61;
    tick();
    idle(); id_src1_a = 5'd10; id_src2_a = 5'd11;
    #1;
    check("num3_src1_a", mt_src1_a, 10);
    check("num3_rdy1_a", mt_rdy1_a, 1);
    check("num3_src2_a", mt_src2_a, 11);
    check("num3_rdy2_a", mt_rdy2_a, 1);

    // Reset overrides dispatch, mispredict and retire in the same cycle.
    idle(); id_dispatch_num = 2'd1; id_dest_a = 5'd12; fl_mt_a = 7'd70;
    tick();
    idle(); reset = 1'b1; id_dispatch_num = 2'd2; id_dest_a = 5'd12; id_dest_b = 5'd13;
    fl_mt_a = 7'd71; fl_mt_b = 7'd72; branch_mispredict = 1'b1;
    rob_retire_num = 2'd1; rob_retire_dest_a = 5'd14; rob_retire_tag_a = 7'd77;
    tick();
    idle(); id_src1_a = 5'd12; id_src2_a = 5'd7; id_src1_b = 5'd13;
    #1;
    check("rst2_src1_a_r12", mt_src1_a, 12);
    check("rst2_rdy1_a_r12", mt_rdy1_a, 1);
    check("rst2_src2_a_r7", mt_src2_a, 7);
    check("rst2_src1_b_r13", mt_src1_b, 13);
    check("rst2_rdy1_b_r13", mt_rdy1_b, 1);
    // Arch map was reset too: recovery restores identity for r14 and r7.
    idle(); branch_mispredict = 1'b1;
    tick();
    idle(); id_src1_a = 5'd14; id_src2_a = 5'd7;
    #1;
    check("rst2_arch_r14", mt_src1_a, 14);
    check("rst2_arch_r7", mt_src2_a, 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- Two-wide register-rename map table; sits directly downstream of the free list in the rename stage.
- Consumes up to two free physical tags per cycle (fl_mt_a/b) and binds them to the dispatching instructions' destination architectural registers.
- Reports renamed source tags with ready bits, plus the displaced old tags (told) that the ROB returns to the free list at retire.
- Keeps a retirement map for single-cycle recovery on branch mispredict.

Parameters:
- NUM_ARCH, 32, architectural registers (index width 5)
- TAG_W, 7, physical tag width (96 physical registers)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- id_dispatch_num  in  2  instructions renamed this cycle (0..2); slot a always used before slot b
- id_dest_a, id_dest_b  in  5  destination arch regs
- id_src1_a, id_src2_a, id_src1_b, id_src2_b  in  5  source arch regs
- fl_mt_a, fl_mt_b  in  7  new tags from free list for slots a, b
- cdb_valid_a, cdb_valid_b  in  1  completion broadcast valid
- cdb_tag_a, cdb_tag_b  in  7  completing tags
- rob_retire_num  in  2  retiring instructions (0..2), a older than b
- rob_retire_dest_a, rob_retire_dest_b  in  5  retiring arch dests
- rob_retire_tag_a, rob_retire_tag_b  in  7  retiring tags (committed mappings)
- branch_mispredict  in  1  recover speculative map from retirement map
- mt_src1_a, mt_src2_a, mt_src1_b, mt_src2_b  out  7  renamed source tags
- mt_rdy1_a, mt_rdy2_a, mt_rdy1_b, mt_rdy2_b  out  1  source value available
- mt_told_a, mt_told_b  out  7  previous mapping of dest a/b

Behaviour:
- State: spec_map[32] (7b), ready[32] (1b), arch_map[32] (7b). All outputs are combinational reads of current state; state updates at posedge clock.
- Reset: spec_map[i] = arch_map[i] = i; ready[i] = 1. Reset overrides every other input. Outputs settle to identity mapping, e.g. mt_src1_a = id_src1_a zero-extended, rdy = 1.
- Source lookup: tag = spec_map[src]; rdy = ready[src] OR (cdb_valid_x AND cdb_tag_x == tag) for either CDB slot, giving same-cycle bypass.
- Intra-bundle forwarding: when id_dispatch_num == 2 and id_src*_b == id_dest_a, slot b's tag = fl_mt_a and rdy = 0, overriding the lookup. Slot a never forwards from b.
- Told:
  - mt_told_a = spec_map[id_dest_a].
  - mt_told_b = fl_mt_a if id_dispatch_num == 2 and id_dest_b == id_dest_a; else spec_map[id_dest_b].
- Dispatch update (branch_mispredict = 0):
  - num >= 1: spec_map[dest_a] <= fl_mt_a; ready[dest_a] <= 0.
  - num == 2: spec_map[dest_b] <= fl_mt_b; ready[dest_b] <= 0. Slot b wins when dests are equal.
  - num == 3 is treated as 0.
- CDB update: for every arch reg j with spec_map[j] == a valid cdb_tag, ready[j] <= 1, evaluated on pre-update state. A dispatch clear to the same arch reg in the same cycle wins, because the new tag cannot be on the CDB.
- Retire update:
  - retire_num >= 1: arch_map[dest_a] <= tag_a.
  - retire_num == 2: arch_map[dest_b] <= tag_b; b wins on equal dests.
  - Retire is independent of dispatch and mispredict.
- Mispredict: spec_map <= next-state arch_map, including the same-cycle retires; all ready <= 1. Dispatch and CDB updates are ignored that cycle, and outputs that cycle are don't-care.
- No zero-register special case; all dests rename uniformly.
- Latency: rename results are combinational in the same cycle; mappings are visible to the next cycle's lookups.

Test Plan:
- Reset, then dispatch_num = 1, dest_a = 3, fl_mt_a = 32 -> told_a = 3. Next cycle src1_a = 3 gives tag 32, rdy 0.
- Cycle after that, cdb_valid_a = 1, cdb_tag_a = 32, src1_a = 3 -> rdy1_a = 1 same cycle. Following cycle, rdy1_a = 1 with no CDB.
- dispatch_num = 2, dest_a = dest_b = 5, fl 40/41, src1_b = 5 -> src1_b = 40, rdy 0, told_a = 5, told_b = 40. Next cycle src1_a = 5 gives 41.
- Rename r7 -> 50 and r8 -> 51, retire (r7, 50), then branch_mispredict -> next cycle r7 reads 50 rdy 1 and r8 reads 8 rdy 1.
- Assert reset while dispatch_num = 2 and mispredict = 1 -> next cycle identity mapping, all ready.
- dispatch_num = 3 with valid free tags -> no state change.
